imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode stage. Accepts 32-bit instructions over a valid/ready handshake, derives the immediate either from an explicit type code or by decoding the opcode itself, and sign-extends it to XLEN (32 or 64). Results are held in a 2-entry skid buffer, so the decode/execute boundary can stall and flush without losing or duplicating instructions.

---
 rtl/imm_pkg.sv | 68 ++++++
 rtl/imm_format_unit.sv | 45 ++++
 rtl/imm_gen_pipe.sv | 142 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Purpose: shared type codes, opcodes, occupancy states and opcode decoder for the immediate generator.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package imm_pkg;

    // Immediate type codes
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;
    localparam logic [2:0] IMM_LOAD = 3'd6;
    localparam logic [2:0] IMM_SYS  = 3'd7;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;  // RV64 only
    localparam logic [6:0] OP_REG_32 = 7'b0111011;  // RV64 only

    // Skid buffer occupancy
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    typedef struct packed {
        logic [2:0] imm_type;
        logic       illegal;
    } dec_t;

    // Opcode -> immediate type. Unknown opcodes map to IMM_NONE so the
    // formatted immediate is zero, and flag illegal.
    function automatic dec_t imm_decode(input logic [6:0] opcode, input logic rv64);
        dec_t d;
        d.imm_type = IMM_NONE;
        d.illegal  = 1'b0;
        case (opcode)
            OP_REG:                      d.imm_type = IMM_NONE;
            OP_IMM, OP_JALR, OP_FENCE:   d.imm_type = IMM_I;
            OP_LOAD:                     d.imm_type = IMM_LOAD;
            OP_STORE:                    d.imm_type = IMM_S;
            OP_BRANCH:                   d.imm_type = IMM_B;
            OP_LUI, OP_AUIPC:            d.imm_type = IMM_U;
            OP_JAL:                      d.imm_type = IMM_J;
            OP_SYSTEM:                   d.imm_type = IMM_SYS;
            OP_IMM_32: begin
                d.imm_type = rv64 ? IMM_I : IMM_NONE;
                d.illegal  = !rv64;
            end
            OP_REG_32:                   d.illegal  = !rv64;
            default:                     d.illegal  = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_format_unit.sv
// Purpose: assemble the RV32I immediate for a given type code and sign-extend bit 31 to XLEN.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
// Ports: instr - instruction word; imm_type - type code; imm - XLEN-wide sign-extended immediate.
module imm_format_unit
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I, IMM_LOAD, IMM_SYS:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:
                imm32 = {instr[31:12], 12'b0};
            IMM_J:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    // Every format already carries bit 31 in imm32[31], so widening is a
    // plain sign extension (U-type included).
    generate
        if (XLEN == 64) begin : g_rv64
            assign imm = {{32{imm32[31]}}, imm32};
        end else begin : g_rv32
            assign imm = imm32;
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Purpose: decode-stage immediate generator with a 2-entry skid buffer on a valid/ready interface.
// Latency: 1 cycle from acceptance to valid_out when empty; 1 instruction/cycle sustained.
// Backpressure: ready_out is registered and drops only when both entries are full; flush empties the buffer.
// Ports: clk_in/rst_n_in (sync active-low); flush_in; valid_in/ready_out/instr_in/imm_type_in upstream;
//        valid_out/ready_in/imm_out/instr_out/illegal_out downstream.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            flush_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [31:0]     instr_in,
    input  logic [2:0]      imm_type_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] imm_out,
    output logic [31:0]     instr_out,
    output logic            illegal_out
);

    occ_state_t state, state_nxt;

    logic            rdy_q;
    logic            in_xfer;
    logic            out_xfer;

    // Type selection and formatting for the incoming instruction
    dec_t            dec;
    logic [2:0]      sel_type;
    logic            sel_illegal;
    logic [XLEN-1:0] new_imm;

    always_comb begin
        dec         = imm_decode(instr_in[6:0], XLEN == 64);
        sel_type    = imm_type_in;
        sel_illegal = 1'b0;
        if (AUTO_DECODE) begin
            sel_type    = dec.imm_type;
            sel_illegal = dec.illegal;
        end
    end

    imm_format_unit #(
        .XLEN (XLEN)
    ) u_format (
        .instr    (instr_in),
        .imm_type (sel_type),
        .imm      (new_imm)
    );

    // Entry registers: head (drives the outputs) and skid
    logic [XLEN-1:0] head_imm,  skid_imm;
    logic [31:0]     head_instr, skid_instr;
    logic            head_ill,  skid_ill;

    // A flushed input is never a transfer, even though ready_out may be high.
    assign in_xfer  = valid_in && rdy_q && !flush_in;
    assign out_xfer = (state != OCC_EMPTY) && ready_in;

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= OCC_EMPTY;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != OCC_TWO);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush_in) begin
            state_nxt = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: if (in_xfer) state_nxt = OCC_ONE;
                OCC_ONE: begin
                    if (in_xfer && !out_xfer)      state_nxt = OCC_TWO;
                    else if (!in_xfer && out_xfer) state_nxt = OCC_EMPTY;
                end
                OCC_TWO:   if (out_xfer) state_nxt = OCC_ONE;
                default:   state_nxt = OCC_EMPTY;
            endcase
        end
    end

    // Output logic: everything comes from registers
    always_comb begin
        valid_out   = (state != OCC_EMPTY);
        ready_out   = rdy_q;
        imm_out     = head_imm;
        instr_out   = head_instr;
        illegal_out = head_ill;
    end

    // Head loads fresh data when it is free or being consumed this cycle,
    // except in TWO where the older skid entry moves up instead.
    logic head_load_new;
    logic head_load_skid;
    logic skid_load;

    always_comb begin
        head_load_new  = !flush_in && in_xfer &&
                         ((state == OCC_EMPTY) || ((state == OCC_ONE) && out_xfer));
        head_load_skid = !flush_in && (state == OCC_TWO) && out_xfer;
        skid_load      = !flush_in && in_xfer && (state == OCC_ONE) && !out_xfer;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            head_imm   <= '0;
            head_instr <= '0;
            head_ill   <= 1'b0;
            skid_imm   <= '0;
            skid_instr <= '0;
            skid_ill   <= 1'b0;
        end else begin
            if (head_load_new) begin
                head_imm   <= new_imm;
                head_instr <= instr_in;
                head_ill   <= sel_illegal;
            end else if (head_load_skid) begin
                head_imm   <= skid_imm;
                head_instr <= skid_instr;
                head_ill   <= skid_ill;
            end
            if (skid_load) begin
                skid_imm   <= new_imm;
                skid_instr <= instr_in;
                skid_ill   <= sel_illegal;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic [31:0] instr;
    logic [2:0]  itype;
    logic        rdy_in;

    // Instance A: XLEN=32 auto; B: XLEN=64 auto; C: XLEN=32 explicit type
    logic        a_vo, a_ro, a_ill;  logic [31:0] a_imm; logic [31:0] a_ins;
    logic        b_vo, b_ro, b_ill;  logic [63:0] b_imm; logic [31:0] b_ins;
    logic        c_vo, c_ro, c_ill;  logic [31:0] c_imm; logic [31:0] c_ins;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  t;
    } ent_t;
    ent_t q[$];
    bit   exp_rdy = 1'b0;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(valid), .ready_out(a_ro),
        .instr_in(instr), .imm_type_in(itype), .valid_out(a_vo), .ready_in(rdy_in),
        .imm_out(a_imm), .instr_out(a_ins), .illegal_out(a_ill));

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(valid), .ready_out(b_ro),
        .instr_in(instr), .imm_type_in(itype), .valid_out(b_vo), .ready_in(rdy_in),
        .imm_out(b_imm), .instr_out(b_ins), .illegal_out(b_ill));

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) dut_c (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(valid), .ready_out(c_ro),
        .instr_in(instr), .imm_type_in(itype), .valid_out(c_vo), .ready_in(rdy_in),
        .imm_out(c_imm), .instr_out(c_ins), .illegal_out(c_ill));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: immediate built arithmetically from the field definitions.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input bit auto_m,
                                            input bit x64, input logic [2:0] t, output bit ill);
        int signed   s;
        longint      v;
        logic [2:0]  typ;
        s   = ins;
        ill = 1'b0;
        typ = t;
        if (auto_m) begin
            case (ins[6:0])
                7'b0110011:                         typ = 0;
                7'b0010011, 7'b1100111, 7'b0001111: typ = 1;
                7'b0000011:                         typ = 6;
                7'b0100011:                         typ = 2;
                7'b1100011:                         typ = 3;
                7'b0110111, 7'b0010111:             typ = 4;
                7'b1101111:                         typ = 5;
                7'b1110011:                         typ = 7;
                7'b0011011: begin typ = x64 ? 3'd1 : 3'd0; ill = !x64; end
                7'b0111011: begin typ = 0; ill = !x64; end
                default:    begin typ = 0; ill = 1'b1; end
            endcase
        end
        case (typ)
            3'd1, 3'd6, 3'd7: v = longint'(s >>> 20);
            3'd2: v = longint'(s >>> 25) * 32 + longint'(ins[11:7]);
            3'd3: v = longint'(s >>> 31) * 4096 + longint'(ins[7]) * 2048
                      + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            3'd4: v = longint'(s) & ~longint'(64'hFFF);
            3'd5: v = longint'(s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                      + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            default: v = 0;
        endcase
        if (x64) return v;
        return {32'b0, v[31:0]};
    endfunction

    task automatic check_inst(input string nm, input bit auto_m, input bit x64,
                              input logic vo, input logic ro, input logic [63:0] imm,
                              input logic [31:0] ins, input logic ill);
        logic [63:0] e_imm;
        bit          e_ill;
        chk({nm, ".ready_out"}, {63'b0, ro}, {63'b0, exp_rdy});
        chk({nm, ".valid_out"}, {63'b0, vo}, {63'b0, q.size() > 0});
        if (q.size() > 0) begin
            e_imm = ref_imm(q[0].ins, auto_m, x64, q[0].t, e_ill);
            chk({nm, ".imm_out"},     imm, e_imm);
            chk({nm, ".instr_out"},   {32'b0, ins}, {32'b0, q[0].ins});
            chk({nm, ".illegal_out"}, {63'b0, ill}, {63'b0, e_ill});
        end
    endtask

    // Called at a negedge: check outputs, drive inputs, advance model, wait one cycle.
    task automatic step(input bit v, input logic [31:0] ins, input logic [2:0] t,
                        input bit r, input bit f);
        bit in_x, out_x;
        check_inst("A", 1'b1, 1'b0, a_vo, a_ro, {32'b0, a_imm}, a_ins, a_ill);
        check_inst("B", 1'b1, 1'b1, b_vo, b_ro, b_imm,          b_ins, b_ill);
        check_inst("C", 1'b0, 1'b0, c_vo, c_ro, {32'b0, c_imm}, c_ins, c_ill);
        valid  = v;
        instr  = ins;
        itype  = t;
        rdy_in = r;
        flush  = f;
        in_x   = v && exp_rdy && !f;
        out_x  = (q.size() > 0) && r;
        if (f) q.delete();
        else begin
            if (out_x) void'(q.pop_front());
            if (in_x)  q.push_back('{ins, t});
        end
        exp_rdy = (q.size() < 2);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm, input logic vo, input logic ro,
                            input logic [63:0] imm, input logic [31:0] ins, input logic ill);
        chk({nm, ".rst_valid"}, {63'b0, vo}, 64'd0);
        chk({nm, ".rst_ready"}, {63'b0, ro}, 64'd0);
        chk({nm, ".rst_imm"},   imm, 64'd0);
        chk({nm, ".rst_instr"}, {32'b0, ins}, 64'd0);
        chk({nm, ".rst_ill"},   {63'b0, ill}, 64'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n  = 1'b0;
        valid  = 1'b0;
        flush  = 1'b0;
        rdy_in = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk_zero("A", a_vo, a_ro, {32'b0, a_imm}, a_ins, a_ill);
            chk_zero("B", b_vo, b_ro, b_imm,          b_ins, b_ill);
            chk_zero("C", c_vo, c_ro, {32'b0, c_imm}, c_ins, c_ill);
        end
        q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        exp_rdy = 1'b1;
        chk("rdy_after_release", {63'b0, a_ro}, 64'd1);
    endtask

    logic [31:0] vec_in [4];
    logic [31:0] vec_exp[4];
    logic [31:0] seq[4];
    logic [6:0]  ops[13];

    initial begin
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; rdy_in = 1'b0;
        instr = '0;   itype = '0;
        vec_in  = '{32'hFFF00093, 32'hFE000EE3, 32'h123452B7, 32'h001000EF};
        vec_exp = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
        seq     = '{32'h00A00093, 32'h00C12223, 32'hFE000EE3, 32'h800002B7};
        ops     = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b0000011,
                    7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                    7'b1110011, 7'b0011011, 7'b0111011};

        do_reset(2);

        // Known vectors, one cycle after acceptance
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vec_in[i], 3'd0, 1'b1, 1'b0);
            chk($sformatf("vec%0d_imm", i), {32'b0, a_imm}, {32'b0, vec_exp[i]});
            chk($sformatf("vec%0d_ill", i), {63'b0, a_ill}, 64'd0);
            chk($sformatf("vec%0d_vld", i), {63'b0, a_vo},  64'd1);
        end
        step(1'b1, 32'h800002B7, 3'd0, 1'b1, 1'b0);
        chk("rv64_lui", b_imm, 64'hFFFFFFFF80000000);
        step(1'b1, 32'hFFF00093, 3'd0, 1'b1, 1'b0);
        chk("rv64_addi", b_imm, 64'hFFFFFFFFFFFFFFFF);
        step(1'b1, 32'h0000007F, 3'd0, 1'b1, 1'b0);
        chk("illegal_flag", {63'b0, a_ill}, 64'd1);
        chk("illegal_imm",  {32'b0, a_imm}, 64'd0);
        step(1'b1, 32'hFE000EE3, 3'd2, 1'b1, 1'b0);
        chk("explicit_s", {32'b0, c_imm}, 64'h00000000FFFFFFFD);
        chk("explicit_ill", {63'b0, c_ill}, 64'd0);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

        // Stall: A,B,C,D back to back with ready_in low for 3 cycles
        begin
            int idx = 0;
            for (int c = 0; c < 10; c++) begin
                bit v;
                bit acc;
                v   = (idx < 4);
                acc = v && exp_rdy;
                step(v, v ? seq[idx] : 32'h0, 3'd1, c >= 3, 1'b0);
                if (c == 1) chk("stall_rdy_fall", {63'b0, a_ro}, 64'd0);
                if (c == 2) chk("stall_rdy_low",  {63'b0, a_ro}, 64'd0);
                if (c == 3) chk("stall_rdy_rise", {63'b0, a_ro}, 64'd1);
                if (acc) idx++;
            end
            chk("stall_all_accepted", 64'(idx), 64'd4);
        end

        // Flush in TWO with a simultaneous input
        step(1'b1, 32'h00100093, 3'd1, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 3'd1, 1'b0, 1'b0);
        step(1'b1, 32'h00300093, 3'd1, 1'b0, 1'b1);
        chk("flush_two_vld", {63'b0, a_vo}, 64'd0);
        chk("flush_two_rdy", {63'b0, a_ro}, 64'd1);
        // Flush in ONE: the presented input must be dropped too
        step(1'b1, 32'h00400093, 3'd1, 1'b0, 1'b0);
        step(1'b1, 32'h00500093, 3'd1, 1'b1, 1'b1);
        chk("flush_one_vld", {63'b0, a_vo}, 64'd0);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

        // Reset with two entries held
        step(1'b1, 32'h00600093, 3'd1, 1'b0, 1'b0);
        step(1'b1, 32'h00700093, 3'd1, 1'b0, 1'b0);
        chk("pre_reset_full", {63'b0, a_ro}, 64'd0);
        do_reset(2);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ri;
            ri = $urandom;
            if ($urandom_range(99) < 85) ri[6:0] = ops[$urandom_range(12)];
            step($urandom_range(99) < 70, ri, 3'($urandom_range(7)),
                 $urandom_range(99) < 60, $urandom_range(99) < 4);
        end
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
